// File: rtl/regfile_seq_ctrl_pkg.sv
// Shared encodings for the register-file/ALU sequencing controller.
// Holds the FSM state encodings, command op codes and ALU op codes used by
// the controller top and its testbench-facing interface.
package regfile_seq_ctrl_pkg;

  // 3-bit state encoding; values 6 and 7 are illegal and recover to WAIT.
  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_GET_A  = 3'd1,
    S_GET_B  = 3'd2,
    S_ALU    = 3'd3,
    S_WB_C   = 3'd4,
    S_WB_IMM = 3'd5
  } state_e;

  // Command op codes as presented on the op input.
  typedef enum logic [1:0] {
    OP_MOVI = 2'b00,
    OP_MOV  = 2'b01,
    OP_ADD  = 2'b10,
    OP_CMP  = 2'b11
  } op_e;

  // ALU operation codes driven on aluop.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

endpackage

// File: rtl/regfile_seq_ctrl_state_reg.sv
// Purpose: plain N-bit D register with synchronous active-high clear.
// Ports: i_clk clock, i_reset sync clear to 0, i_d next value, o_q current value.
// Latency: one clock; no enable (callers feed back o_q to hold).
module state_reg #(
  parameter int N = 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q <= '0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/regfile_seq_ctrl.sv
// Purpose: multi-cycle Moore controller sequencing the regfile/A/B/C/status
//   datapath for MOVI, MOV, ADD and CMP, one micro-step per clock.
// Ports: i_clk/i_reset (sync, active-high), command in (i_start, i_op, i_rd,
//   i_rn, i_rm, i_shift_in), o_done ready flag, regfile index/write controls,
//   A/B/C/status load strobes, mux selects, o_aluop and o_shift.
// Latency start->done: MOVI 2, MOV 4, ADD 5, CMP 4 cycles; start ignored while busy.
module regfile_seq_ctrl
  import regfile_seq_ctrl_pkg::*;
#(
  parameter int RBITS = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [RBITS-1:0] i_rd,
  input  logic [RBITS-1:0] i_rn,
  input  logic [RBITS-1:0] i_rm,
  input  logic [1:0]       i_shift_in,
  output logic             o_done,
  output logic [RBITS-1:0] o_readnum,
  output logic [RBITS-1:0] o_writenum,
  output logic             o_write,
  output logic             o_vsel,
  output logic             o_loada,
  output logic             o_loadb,
  output logic             o_asel,
  output logic             o_bsel,
  output logic             o_loadc,
  output logic             o_loads,
  output logic [1:0]       o_aluop,
  output logic [1:0]       o_shift
);

  // Latched command layout: {op, rd, rn, rm, shift}.
  localparam int FW = 2 + 3 * RBITS + 2;

  logic [2:0]    w_state_q;
  logic [2:0]    w_state_d;
  state_e        w_state;
  logic [FW-1:0] w_fields_q;
  logic [FW-1:0] w_fields_d;
  logic          w_accept;

  op_e             w_op;
  logic [RBITS-1:0] w_rd;
  logic [RBITS-1:0] w_rn;
  logic [RBITS-1:0] w_rm;
  logic [1:0]       w_sh;

  state_reg #(.N(3)) u_state_reg (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (w_state_d),
    .o_q     (w_state_q)
  );

  state_reg #(.N(FW)) u_fields_reg (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (w_fields_d),
    .o_q     (w_fields_q)
  );

  assign w_state  = state_e'(w_state_q);
  assign w_accept = (w_state == S_WAIT) && i_start;

  // Fields only change on the accepting edge so later input wiggles are ignored.
  assign w_fields_d = w_accept ? {i_op, i_rd, i_rn, i_rm, i_shift_in} : w_fields_q;

  assign w_op = op_e'(w_fields_q[3*RBITS+3 : 3*RBITS+2]);
  assign w_rd = w_fields_q[3*RBITS+1 : 2*RBITS+2];
  assign w_rn = w_fields_q[2*RBITS+1 : RBITS+2];
  assign w_rm = w_fields_q[RBITS+1 : 2];
  assign w_sh = w_fields_q[1:0];

  // Next-state and Moore outputs; outputs depend only on state and latched fields.
  always_comb begin
    w_state_d  = S_WAIT;
    o_done     = 1'b0;
    o_readnum  = '0;
    o_writenum = '0;
    o_write    = 1'b0;
    o_vsel     = 1'b0;
    o_loada    = 1'b0;
    o_loadb    = 1'b0;
    o_asel     = 1'b0;
    o_bsel     = 1'b0;
    o_loadc    = 1'b0;
    o_loads    = 1'b0;
    o_aluop    = ALU_ADD;
    o_shift    = 2'b00;

    case (w_state)
      S_WAIT: begin
        o_done = 1'b1;
        if (i_start) begin
          // Branch on the live op: it is the value being latched this edge.
          case (op_e'(i_op))
            OP_MOVI: w_state_d = S_WB_IMM;
            OP_MOV:  w_state_d = S_GET_B;
            default: w_state_d = S_GET_A;
          endcase
        end else begin
          w_state_d = S_WAIT;
        end
      end
      S_GET_A: begin
        o_readnum = w_rn;
        o_loada   = 1'b1;
        w_state_d = S_GET_B;
      end
      S_GET_B: begin
        o_readnum = w_rm;
        o_loadb   = 1'b1;
        o_shift   = w_sh;
        w_state_d = S_ALU;
      end
      S_ALU: begin
        o_shift = w_sh;
        case (w_op)
          OP_MOV: begin
            // A forced to zero so C = 0 + shifted B.
            o_asel    = 1'b1;
            o_loadc   = 1'b1;
            w_state_d = S_WB_C;
          end
          OP_CMP: begin
            // Only status is updated; no writeback follows.
            o_aluop   = ALU_SUB;
            o_loads   = 1'b1;
            w_state_d = S_WAIT;
          end
          default: begin
            o_loadc   = 1'b1;
            w_state_d = S_WB_C;
          end
        endcase
      end
      S_WB_C: begin
        o_writenum = w_rd;
        o_write    = 1'b1;
        w_state_d  = S_WAIT;
      end
      S_WB_IMM: begin
        o_writenum = w_rd;
        o_vsel     = 1'b1;
        o_write    = 1'b1;
        w_state_d  = S_WAIT;
      end
      default: begin
        w_state_d = S_WAIT;
      end
    endcase
  end

endmodule
